// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges ALU (E) and load (M) results onto one
// register-file write port, M first, with a starvation-bounded E holding slot.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic [4:0]  e_dst,
  input  logic [31:0] e_wdata,
  input  logic [31:0] e_pc,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_dst,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_pc,
  output logic        wb_en,
  output logic        wb_sel,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_pc,
  output logic        e_stall
);

  localparam int CW =
    (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CLIM = CW'(STARVE_LIMIT);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HELD  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    hdst_q, hdst_d;
  logic [31:0]   hwd_q, hwd_d;
  logic [31:0]   hpc_q, hpc_d;

  logic          wb_en_q, wb_sel_q;
  logic [4:0]    wb_dst_q;
  logic [31:0]   wb_wd_q, wb_pc_q;

  logic          iss, isel;
  logic [4:0]    idst;
  logic [31:0]   iwd, ipc;

  logic          st_empty, st_held, st_force;
  logic          e_acc, m_acc;

  assign st_empty = (state_q == S_EMPTY);
  assign st_held  = (state_q == S_HELD);
  assign st_force = (state_q == S_FORCE);

  assign e_ready  = st_empty;
  assign m_ready  = ~st_force;
  assign e_stall  = ~st_empty;

  assign e_acc    = e_valid & e_ready;
  assign m_acc    = m_valid & m_ready;

  // Saturating increment: never wraps back to zero.
  assign cnt_inc  = (cnt_q == CLIM) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdst_d  = hdst_q;
    hwd_d   = hwd_q;
    hpc_d   = hpc_q;
    iss     = 1'b0;
    isel    = 1'b0;
    idst    = '0;
    iwd     = '0;
    ipc     = '0;
    unique case (1'b1)
      st_empty: begin
        if (m_acc) begin
          iss  = 1'b1;
          isel = 1'b1;
          idst = m_dst;
          iwd  = m_wdata;
          ipc  = m_pc;
          if (e_acc) begin
            hdst_d  = e_dst;
            hwd_d   = e_wdata;
            hpc_d   = e_pc;
            cnt_d   = '0;
            state_d = S_HELD;
          end
        end else if (e_acc) begin
          iss  = 1'b1;
          idst = e_dst;
          iwd  = e_wdata;
          ipc  = e_pc;
        end
      end
      st_held: begin
        iss = 1'b1;
        if (m_acc) begin
          isel  = 1'b1;
          idst  = m_dst;
          iwd   = m_wdata;
          ipc   = m_pc;
          cnt_d = cnt_inc;
          if (cnt_inc == CLIM) state_d = S_FORCE;
        end else begin
          idst    = hdst_q;
          iwd     = hwd_q;
          ipc     = hpc_q;
          state_d = S_EMPTY;
        end
      end
      st_force: begin
        iss     = 1'b1;
        idst    = hdst_q;
        iwd     = hwd_q;
        ipc     = hpc_q;
        cnt_d   = '0;
        state_d = S_EMPTY;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_EMPTY;
      cnt_q    <= '0;
      hdst_q   <= '0;
      hwd_q    <= '0;
      hpc_q    <= '0;
      wb_en_q  <= 1'b0;
      wb_sel_q <= 1'b0;
      wb_dst_q <= '0;
      wb_wd_q  <= '0;
      wb_pc_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdst_q   <= hdst_d;
      hwd_q    <= hwd_d;
      hpc_q    <= hpc_d;
      wb_en_q  <= iss & (|idst);
      wb_sel_q <= isel;
      wb_dst_q <= idst;
      wb_wd_q  <= iwd;
      wb_pc_q  <= ipc;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_sel   = wb_sel_q;
  assign wb_dst   = wb_dst_q;
  assign wb_wdata = wb_wd_q;
  assign wb_pc    = wb_pc_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive cycles a held E entry may lose to M before it is forced out.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports e_valid in 1, e_ready out 1, e_dst in 5, e_wdata in 32, e_pc in 32: the execute-result (ALU) writeback requester.
REQ-005 SHALL have ports m_valid in 1, m_ready out 1, m_dst in 5, m_wdata in 32, m_pc in 32: the memory-result (load) writeback requester.
REQ-006 SHALL have ports wb_en out 1, wb_sel out 1 (0=E, 1=M), wb_dst out 5, wb_wdata out 32, wb_pc out 32: the single register-file write port.
REQ-007 SHALL have port e_stall, output, 1: high while the E holding register is occupied; drives the upstream pipeline stall.

Function
REQ-008 SHALL accept a request on a source when valid and ready are both high in the same cycle.
REQ-009 SHALL register all wb_* outputs, so an issued request appears on wb_* exactly 1 cycle after its issue cycle.
REQ-010 SHALL issue at most one request per cycle. wb_* SHALL hold the issued request's fields. wb_en SHALL be 1 only if something was issued and its dst != 0.
REQ-011 SHALL, when nothing issues, drive wb_en=0, with wb_sel, wb_dst, wb_wdata and wb_pc all zero.
REQ-012 SHALL keep a 1-entry E holding register (dst, wdata, pc) and a state machine with states EMPTY, HELD and FORCE.
REQ-013 SHALL drive e_ready = (state == EMPTY), decoded from registered state only, with no combinational path from any valid input.
REQ-014 SHALL drive m_ready = (state != FORCE), decoded from registered state only.
REQ-015 EMPTY, e_valid only: SHALL issue E directly (wb_sel=0) and stay in EMPTY.
REQ-016 EMPTY, m_valid only: SHALL issue M (wb_sel=1) and stay in EMPTY.
REQ-017 EMPTY, both valid: SHALL issue M, capture E into the holding register, clear the starve counter, and go to HELD. M is the older instruction; a same-dst E write therefore lands after it.
REQ-018 HELD, m_valid low: SHALL issue the held entry (wb_sel=0) and go to EMPTY.
REQ-019 HELD, m_valid high: SHALL issue M and increment the starve counter. When the incremented value equals STARVE_LIMIT, SHALL go to FORCE; otherwise stay in HELD.
REQ-020 FORCE: SHALL issue the held entry (m_ready=0, so M is not accepted), clear the starve counter, and go to EMPTY.
REQ-021 The starve counter SHALL be wide enough for STARVE_LIMIT. It SHALL saturate and never wrap.
REQ-022 e_stall SHALL be 1 in HELD and FORCE and 0 in EMPTY.
REQ-023 SHALL never drop or duplicate an accepted request.
REQ-024 SHALL issue requests from the same source in acceptance order.
REQ-025 SHALL ignore e_dst, e_wdata and e_pc when e_ready=0, and m_* payload when m_ready=0.
REQ-026 dst=0 requests SHALL be accepted and consume an issue slot, but produce wb_en=0.

Reset
REQ-027 SHALL, while resetn=0, immediately and asynchronously set state to EMPTY, clear the starve counter and the holding register, and drive wb_en=0, wb_sel=0, wb_dst=0, wb_wdata=0, wb_pc=0.
REQ-028 Immediately after reset SHALL drive e_ready=1, m_ready=1, e_stall=0.
REQ-029 Assertion of resetn mid-operation SHALL discard any held entry; deassertion SHALL take effect synchronously at the next rising clk edge.

Verification
REQ-030 Single E: e_valid=1, dst=5, wdata=0x1234 in cycle 0 -> next cycle wb_en=1, wb_sel=0, wb_dst=5, wb_wdata=0x1234; state stays EMPTY.
REQ-031 Collision: both valid in cycle 0, M dst=3/0xAA, E dst=3/0xBB -> cycle 1 writes 3=0xAA (sel=1), cycle 2 writes 3=0xBB (sel=0); e_ready=0 and e_stall=1 in cycle 1.
REQ-032 Starvation, STARVE_LIMIT=3: collision in cycle 0, m_valid held high afterwards -> M wins cycles 1-3, m_ready=0 in cycle 4, held E appears on wb_* in cycle 5, then state is EMPTY.
REQ-033 Zero dst: m_valid=1, m_dst=0, m_wdata=0xFFFF -> m_ready=1, accepted, next cycle wb_en=0.
REQ-034 Reset mid-HELD: collision, then resetn=0 for 1 cycle -> all wb_* zero immediately, e_ready=1; held E is never written after reset release.
